token_table_arbiter: RTL and testbench
======================================

Name: token_table_arbiter

Overview:
- Shares the single port of the decompressor's token conversion table between two requesters.
  - The decode path issues one lookup per compressed instruction.
  - A table loader streams new token entries in bursts.
- Sits between the decompressor's table-management logic and the token table write/read port.
- Drives a stall to the CPU-side control while the table is unavailable for lookups.
- Fixed decoder priority, with a starvation limit so loader bursts always make progress.

Parameters:
- WIDTH, 32, table word width.
- ADDR_W, 7, table address width.
- SIZE, 102, number of valid table entries; legal addresses are 0..SIZE-1.
- STARVE_LIM, 8, consecutive lost arbitrations after which the loader wins.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dec_req  input  1  decoder lookup request.
- dec_addr  input  ADDR_W  lookup address.
- dec_gnt  output  1  lookup granted this cycle (combinational).
- dec_valid  output  1  table read data valid (registered).
- ld_req  input  1  loader burst request, level held until ld_done.
- ld_base  input  ADDR_W  first write address, sampled at grant.
- ld_len  input  ADDR_W+1  word count, sampled at grant.
- ld_wvalid  input  1  write word valid.
- ld_wdata  input  WIDTH  write word.
- ld_wready  output  1  arbiter accepts a word.
- ld_done  output  1  one-cycle burst completion pulse.
- tbl_addr  output  ADDR_W  table address.
- tbl_wdata  output  WIDTH  table write data.
- tbl_we  output  1  table write enable.
- stall  output  1  table unavailable to the decoder.
- err  output  1  sticky burst-range error.

Behaviour:
- Reset (async, any state, including mid-burst):
  - State goes to IDLE.
  - All outputs, ptr, cnt and starve_cnt are cleared to 0.
  - Table contents already written are not touched.
- States:
  - IDLE: read service.
  - LOAD: burst in progress.
  - DONE: one cycle, ld_done=1.
- IDLE arbitration, each cycle:
  - If dec_req=1 and !(ld_req && starve_cnt==STARVE_LIM):
    - dec_gnt=1, tbl_addr=dec_addr, tbl_we=0.
    - If ld_req=1, starve_cnt increments, saturating at STARVE_LIM.
  - Else if ld_req=1 (loader grant):
    - Latch base into ptr and len into cnt; clear starve_cnt.
    - If ld_base+ld_len > SIZE (computed ADDR_W+2 bits wide): set err, go to DONE, no writes.
    - Else if ld_len==0: go to DONE.
    - Else: go to LOAD.
  - If ld_req=0, starve_cnt is cleared.
- Read pipeline:
  - dec_valid is dec_gnt delayed one cycle (synchronous-read table).
  - Back-to-back grants are allowed: one lookup per cycle.
- LOAD:
  - dec_gnt=0 and ld_wready=1.
  - On each cycle with ld_wvalid=1: tbl_we=1, tbl_addr=ptr, tbl_wdata=ld_wdata, ptr+1, cnt-1.
  - When the word taken with cnt==1 is accepted, go to DONE.
  - ld_wvalid=0 inserts an idle cycle with no write and no timeout.
- DONE:
  - ld_done=1, then return to IDLE.
  - ld_req must be deasserted by the loader on seeing ld_done. If it is still high in IDLE, it is treated as a new request.
- stall = (state!=IDLE) | (dec_req & ~dec_gnt).
- tbl_we=0 outside LOAD. tbl_addr holds its last value when not driven.
- err is cleared only by reset.

Optional Feature:
- Macro TBL_WRAP_EN.
- Defined:
  - No range check at grant; err is tied to 0.
  - ptr wraps from SIZE-1 to 0 during LOAD, so a burst starting at 100 with length 4 writes 100, 101, 0, 1.
- Undefined:
  - The range check and sticky err apply as described in Behaviour.

Test Plan:
- Reset, then dec_req=1 with dec_addr=5 for 3 cycles:
  - dec_gnt=1 each cycle, tbl_addr=5, dec_valid=1 on cycles 2-4, stall=0.
- ld_req with base=10, len=3, wdata 0xA, 0xB, 0xC, with one ld_wvalid=0 gap:
  - tbl_we pulses at addresses 10, 11, 12 with data A, B, C.
  - Exactly one ld_done follows; stall=1 from grant until the DONE cycle.
- dec_req held high and ld_req asserted:
  - Decoder wins 8 cycles, the loader is granted on the 9th.
  - dec_gnt=0 and stall=1 during the burst.
- ld_req with base=100, len=5 (without TBL_WRAP_EN):
  - err=1, ld_done pulse, no tbl_we.
  - err stays 1 until reset.
- ld_req with base=0, len=0:
  - ld_done the cycle after grant, no writes, err stays 0.
- Reset asserted after 2 of 4 burst words:
  - State returns to IDLE, ld_wready=0, ld_done never pulses.
  - A new burst after reset completes normally.

Source files
------------

// File: rtl/token_table_arbiter.sv
// Arbitrates the token table port between decoder lookups and loader bursts.
// Optional macro TBL_WRAP_EN: burst pointer wraps at SIZE and the range check/err are removed.
module token_table_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 7,
  parameter int SIZE       = 102,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic              dec_gnt,
  output logic              dec_valid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_wvalid,
  input  logic [WIDTH-1:0]  ld_wdata,
  output logic              ld_wready,
  output logic              ld_done,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [WIDTH-1:0]  tbl_wdata,
  output logic              tbl_we,
  output logic              stall,
  output logic              err
);
  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic [SC_W-1:0]   r_starve;
  logic              r_dec_valid;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [WIDTH-1:0]  r_wdata_hold;

  logic              w_idle;
  logic              w_ld_win;
  logic              w_dec_gnt;
  logic              w_wr;
  logic              w_range_bad;
  logic [ADDR_W-1:0] w_ptr_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_ld_win  = w_idle & ld_req & (~dec_req | (r_starve == SC_W'(STARVE_LIM)));
  // Gated by reset so the combinational grant is also quiet while reset is held.
  assign w_dec_gnt = w_idle & dec_req & ~w_ld_win & ~reset;
  assign w_wr      = (r_state == S_LOAD) & ld_wvalid;

`ifdef TBL_WRAP_EN
  assign w_range_bad = 1'b0;
  assign w_ptr_nxt   = (r_ptr == ADDR_W'(SIZE - 1)) ? '0 : r_ptr + 1'b1;
  assign err         = 1'b0;
`else
  logic              r_err;
  logic [ADDR_W+1:0] w_end;
  assign w_end       = {2'b00, ld_base} + {1'b0, ld_len};
  assign w_range_bad = (w_end > (ADDR_W+2)'(SIZE));
  assign w_ptr_nxt   = r_ptr + 1'b1;
  assign err         = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_err <= 1'b0;
    else if (w_ld_win & w_range_bad) r_err <= 1'b1;
  end
`endif

  assign dec_gnt   = w_dec_gnt;
  assign dec_valid = r_dec_valid;
  assign tbl_we    = w_wr;
  assign tbl_addr  = w_dec_gnt ? dec_addr : (w_wr ? r_ptr : r_addr_hold);
  assign tbl_wdata = w_wr ? ld_wdata : r_wdata_hold;
  assign ld_wready = (r_state == S_LOAD);
  assign ld_done   = (r_state == S_DONE);
  assign stall     = ~reset & (~w_idle | (dec_req & ~w_dec_gnt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_starve     <= '0;
      r_dec_valid  <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_dec_valid <= w_dec_gnt;
      if (w_dec_gnt) r_addr_hold <= dec_addr;
      if (w_wr) begin
        r_addr_hold  <= r_ptr;
        r_wdata_hold <= ld_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (!ld_req)
            r_starve <= '0;
          else if (w_dec_gnt && r_starve != SC_W'(STARVE_LIM))
            r_starve <= r_starve + 1'b1;
          if (w_ld_win) begin
            r_starve <= '0;
            r_ptr    <= ld_base;
            r_cnt    <= ld_len;
            if (w_range_bad || ld_len == '0) r_state <= S_DONE;
            else                             r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // ld_wvalid low is simply an idle beat; there is no timeout.
          if (w_wr) begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == (ADDR_W+1)'(1)) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_token_table_arbiter.sv
// Directed bench for token_table_arbiter with a queue-based reference model checked every cycle.
module tb_token_table_arbiter;
  localparam int WIDTH = 32, ADDR_W = 7, SIZE = 102, LIM = 8;

  logic              clk = 1'b0, reset = 1'b1;
  logic              dec_req = 1'b0, ld_req = 1'b0, ld_wvalid = 1'b0;
  logic [ADDR_W-1:0] dec_addr = '0, ld_base = '0;
  logic [ADDR_W:0]   ld_len = '0;
  logic [WIDTH-1:0]  ld_wdata = '0;
  logic              dec_gnt, dec_valid, ld_wready, ld_done, tbl_we, stall, err;
  logic [ADDR_W-1:0] tbl_addr;
  logic [WIDTH-1:0]  tbl_wdata;

  token_table_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SIZE(SIZE), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset), .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt),
    .dec_valid(dec_valid), .ld_req(ld_req), .ld_base(ld_base), .ld_len(ld_len),
    .ld_wvalid(ld_wvalid), .ld_wdata(ld_wdata), .ld_wready(ld_wready), .ld_done(ld_done),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_we(tbl_we), .stall(stall), .err(err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pending write addresses as a queue, DONE as a flag.
  int m_q[$];
  bit m_done = 0, m_err = 0, m_dv = 0;
  int m_lost = 0, m_addr = 0, m_wdata = 0;
  int log_a[$], log_d[$];
  int done_seen = 0;

  always @(negedge clk) begin
    bit e_gnt, e_we, e_rdy, e_done, e_stall, lw, rng_bad;
    int e_addr, e_wd, a;
    if (reset) begin
      chk("rst_gnt", dec_gnt, 0);     chk("rst_dv", dec_valid, 0);
      chk("rst_rdy", ld_wready, 0);   chk("rst_done", ld_done, 0);
      chk("rst_we", tbl_we, 0);       chk("rst_addr", tbl_addr, 0);
      chk("rst_wdata", tbl_wdata, 0); chk("rst_stall", stall, 0);
      chk("rst_err", err, 0);
      m_q.delete(); m_done = 0; m_err = 0; m_dv = 0; m_lost = 0; m_addr = 0; m_wdata = 0;
    end else begin
      e_gnt = 0; e_we = 0; e_rdy = 0; e_done = 0; e_stall = 0; lw = 0;
      e_addr = m_addr; e_wd = m_wdata;
      if (m_done) begin
        e_done = 1; e_stall = 1;
      end else if (m_q.size() > 0) begin
        e_rdy = 1; e_stall = 1;
        if (ld_wvalid) begin e_we = 1; e_addr = m_q[0]; e_wd = int'(ld_wdata); end
      end else begin
        lw = ld_req && (!dec_req || m_lost == LIM);
        e_gnt = dec_req && !lw;
        if (e_gnt) e_addr = int'(dec_addr);
        e_stall = dec_req && !e_gnt;
      end
      chk("dec_gnt", dec_gnt, e_gnt);     chk("dec_valid", dec_valid, m_dv);
      chk("tbl_we", tbl_we, e_we);        chk("tbl_addr", tbl_addr, e_addr);
      chk("tbl_wdata", tbl_wdata, e_wd);  chk("ld_wready", ld_wready, e_rdy);
      chk("ld_done", ld_done, e_done);    chk("stall", stall, e_stall);
      chk("err", err, m_err);
      if (tbl_we) begin log_a.push_back(int'(tbl_addr)); log_d.push_back(int'(tbl_wdata)); end
      if (ld_done) done_seen++;
      m_dv = e_gnt;
      if (m_done) m_done = 0;
      else if (m_q.size() > 0) begin
        if (ld_wvalid) begin
          m_addr = m_q.pop_front(); m_wdata = int'(ld_wdata);
          if (m_q.size() == 0) m_done = 1;
        end
      end else begin
        if (e_gnt) m_addr = int'(dec_addr);
        if (!ld_req) m_lost = 0;
        else if (e_gnt && m_lost < LIM) m_lost++;
        if (lw) begin
          m_lost = 0;
          rng_bad = 0;
`ifndef TBL_WRAP_EN
          rng_bad = (int'(ld_base) + int'(ld_len) > SIZE);
`endif
          if (rng_bad) begin m_err = 1; m_done = 1; end
          else if (ld_len == 0) m_done = 1;
          else begin
            a = int'(ld_base);
            for (int i = 0; i < int'(ld_len); i++) begin
              m_q.push_back(a);
`ifdef TBL_WRAP_EN
              a = (a == SIZE - 1) ? 0 : (a + 1) % 128;
`else
              a = a + 1;
`endif
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_burst(input int base, input int len, input bit gap, input bit dreq,
                           input int abort_at, output int dones, output int wins);
    int idx, att; bit fin;
    idx = 0; att = 0; dones = 0; wins = 0; fin = 0;
    ld_base = ADDR_W'(base); ld_len = (ADDR_W+1)'(len); ld_req = 1; dec_req = dreq; dec_addr = 7'd7;
    for (int c = 0; c < 60 && !fin; c++) begin
      ld_wvalid = !(gap && att == 1);
      ld_wdata  = WIDTH'(32'hA + idx);
      @(negedge clk);
      if (dec_gnt) wins++;
      if (ld_wready && ld_wvalid) idx++;
      if (ld_wready) att++;
      if (ld_done) begin dones++; fin = 1; end
      if (abort_at > 0 && idx == abort_at) fin = 1;
      @(posedge clk); #1;
    end
    chk("burst_finished", fin, 1);
    ld_req = 0; ld_wvalid = 0; dec_req = 0;
  endtask

  task automatic chk_log(input int start, input int n, input int a0);
    int a;
    chk("log_len", log_a.size(), start + n);
    for (int i = 0; i < n; i++) begin
      a = a0 + i;
      if (a >= SIZE) a -= SIZE;
      if (start + i < log_a.size()) begin
        chk("log_addr", log_a[start+i], a);
        chk("log_data", log_d[start+i], 32'hA + i);
      end
    end
  endtask

  initial begin
    int g, dv, st, dones, wins, l0, d0;
    idle(2);
    reset = 0;

    // Three back-to-back lookups at address 5
    g = 0; dv = 0; st = 0;
    dec_addr = 7'd5;
    for (int c = 0; c < 4; c++) begin
      dec_req = (c < 3);
      @(negedge clk);
      g += int'(dec_gnt);
      if (c > 0) dv += int'(dec_valid);
      st += int'(stall);
      if (c < 3) chk("lookup_addr", tbl_addr, 5);
      @(posedge clk); #1;
    end
    chk("lookup_gnts", g, 3); chk("lookup_valids", dv, 3); chk("lookup_stall", st, 0);
    idle(1);

    // Burst 10..12 with a one-beat gap
    l0 = log_a.size(); d0 = done_seen;
    run_burst(10, 3, 1, 0, 0, dones, wins);
    idle(3);
    chk_log(l0, 3, 10);
    chk("burst_done_once", done_seen - d0, 1);

    // Zero-length burst
    l0 = log_a.size(); d0 = done_seen;
    run_burst(0, 0, 0, 0, 0, dones, wins);
    idle(2);
    chk("zero_len_writes", log_a.size(), l0);
    chk("zero_len_done", done_seen - d0, 1);
    chk("zero_len_err", err, 0);

    // Starvation limit: decoder wins LIM times, then loader proceeds
    l0 = log_a.size();
    run_burst(40, 2, 0, 1, 0, dones, wins);
    idle(2);
    chk("starve_wins", wins, 8);
    chk_log(l0, 2, 40);

`ifdef TBL_WRAP_EN
    l0 = log_a.size();
    run_burst(100, 4, 0, 0, 0, dones, wins);
    idle(2);
    chk_log(l0, 4, 100);
    chk("wrap_err", err, 0);
`else
    // Out-of-range burst: error, done pulse, nothing written
    l0 = log_a.size();
    run_burst(100, 5, 0, 0, 0, dones, wins);
    idle(2);
    chk("range_done", dones, 1);
    chk("range_writes", log_a.size(), l0);
    chk("range_err", err, 1);
    run_burst(0, 0, 0, 0, 0, dones, wins);
    idle(2);
    chk("err_sticky", err, 1);
`endif

    // Reset after 2 of 4 words
    d0 = done_seen;
    run_burst(20, 4, 0, 0, 2, dones, wins);
    reset = 1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("abort_wready", ld_wready, 0);
    chk("abort_err", err, 0);
    @(posedge clk); #1;
    idle(3);
    chk("abort_no_done", done_seen - d0, 0);

    // Normal burst after reset
    l0 = log_a.size();
    run_burst(30, 2, 0, 0, 0, dones, wins);
    idle(2);
    chk("post_rst_done", dones, 1);
    chk_log(l0, 2, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
